// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-packet lock that feeds one UART TX byte engine.
// Latency: byte accepted at cycle T, tx_start pulse at T+1; next accept after tx_busy falls (+GAP_CLKS).
// Backpressure: req_ready is a one-hot strobe, only asserted in IDLE; sources simply hold req_valid.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int GAP_CLKS     = 0,
    parameter int LOCK_TIMEOUT = 50000
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*8-1:0]         req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      active,
    output logic                      err
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic            active_q, active_d;
    logic            err_q, err_d;
    logic [1:0]      wait_cnt_q, wait_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;

    logic [NREQ-1:0] owner_onehot;
    logic [NREQ-1:0] cand;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] ready_c;

    // Advance a source index by one with wrap at NREQ.
    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] v);
        if (int'(v) == NREQ - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    assign owner_onehot = NREQ'(1) << grant_q;
    assign cand         = lock_q ? (req_valid & owner_onehot) : req_valid;

    // Rotating-priority search: first candidate at or above rr_ptr, wrapping.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    // Sequencer next-state: accept, launch, track busy window, optional gap, lock bookkeeping.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        active_d   = active_q;
        err_d      = 1'b0;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        to_cnt_d   = '0;
        ready_c    = '0;

        case (state_q)
            IDLE: begin
                active_d = 1'b0;
                if (win_found) begin
                    ready_c   = NREQ'(1) << win_idx;
                    tx_data_d = req_data[int'(win_idx)*8 +: 8];
                    grant_d   = win_idx;
                    active_d  = 1'b1;
                    state_d   = START;
                    if (req_last[win_idx]) begin
                        // Packet end is the only point the rotation moves on.
                        lock_d   = 1'b0;
                        rr_ptr_d = ptr_inc(win_idx);
                    end else begin
                        lock_d = 1'b1;
                    end
                end else if (lock_q && !req_valid[grant_q]) begin
                    // Owner went quiet mid-packet; give the line away after the timeout.
                    if (to_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                        err_d    = 1'b1;
                        lock_d   = 1'b0;
                        rr_ptr_d = ptr_inc(grant_q);
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            START: begin
                wait_cnt_d = '0;
                state_d    = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (wait_cnt_q == 2'd2) begin
                    // Engine never picked the byte up: drop it and abandon the packet.
                    err_d    = 1'b1;
                    lock_d   = 1'b0;
                    rr_ptr_d = ptr_inc(grant_q);
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (GAP_CLKS > 0) begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(GAP_CLKS - 1)) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any sequence in progress.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            active_q   <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            active_q   <= active_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // The accept strobe is combinational, so hold it low while reset is asserted.
    assign req_ready = sys_rst ? '0 : ready_c;
    assign tx_start  = (state_q == START);
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_q;
    assign active    = active_q;
    assign err       = err_q;

endmodule
